// File: rtl/brick_pkg.sv
// Shared types, axis codes and brick-index helpers for the brick-field controller.
package brick_pkg;

  typedef enum logic [1:0] {IDLE, PROBE, COMMIT, LOAD} brick_state_t;

  localparam int DIR_DOWN_BIT  = 1;
  localparam int DIR_RIGHT_BIT = 0;

  localparam logic [1:0] AXIS_NONE = 2'b00;
  localparam logic [1:0] AXIS_VERT = 2'b01;
  localparam logic [1:0] AXIS_HORZ = 2'b10;
  localparam logic [1:0] AXIS_DIAG = 2'b11;

  function automatic int calc_bpr(input int grid_cols, input int brick_w);
    return grid_cols / brick_w;
  endfunction

  function automatic int calc_n(input int brick_rows, input int grid_cols, input int brick_w);
    return brick_rows * calc_bpr(grid_cols, brick_w);
  endfunction

  function automatic int calc_index(input int r, input int c, input int row_offset,
                                    input int bpr, input int brick_w);
    return (r - row_offset) * bpr + c / brick_w;
  endfunction

  function automatic logic cell_valid(input int r, input int c, input int row_offset,
                                      input int brick_rows, input int grid_cols);
    return (r >= row_offset) && (r < row_offset + brick_rows) && (c >= 0) && (c < grid_cols);
  endfunction

endpackage

// File: rtl/brick_field_ctrl_probe_addr.sv
// Maps the latched ball position, direction and probe step to a candidate brick.
module brick_probe_addr
  import brick_pkg::*;
#(
  parameter int GRID_COLS  = 16,
  parameter int BRICK_W    = 2,
  parameter int BRICK_ROWS = 7,
  parameter int ROW_OFFSET = 1,
  parameter int POS_W      = 4,
  parameter int IDX_W      = 6
) (
  input  logic [POS_W-1:0] row,
  input  logic [POS_W-1:0] col,
  input  logic [1:0]       dir,
  input  logic [1:0]       idx,
  output logic             valid,
  output logic [IDX_W-1:0] brick_index,
  output logic [1:0]       axis
);

  localparam int BPR = calc_bpr(GRID_COLS, BRICK_W);

  int   dy, dx, cand_r, cand_c, cand_idx, base_idx;
  logic cand_ok, base_ok;

  // Integer coordinates cannot wrap, so off-field neighbours simply fail the band test.
  // Horizontal steps that stay inside the unshifted brick are rejected as duplicates.
  always_comb begin
    dy       = dir[DIR_DOWN_BIT] ? 1 : -1;
    dx       = dir[DIR_RIGHT_BIT] ? 1 : -1;
    cand_r   = int'(row) + (idx[0] ? dy : 0);
    cand_c   = int'(col) + (idx[1] ? dx : 0);
    cand_idx = calc_index(cand_r, cand_c, ROW_OFFSET, BPR, BRICK_W);
    base_idx = calc_index(cand_r, int'(col), ROW_OFFSET, BPR, BRICK_W);
    cand_ok  = cell_valid(cand_r, cand_c, ROW_OFFSET, BRICK_ROWS, GRID_COLS);
    base_ok  = cell_valid(cand_r, int'(col), ROW_OFFSET, BRICK_ROWS, GRID_COLS);
    valid       = cand_ok && !(idx[1] && base_ok && (cand_idx == base_idx));
    brick_index = IDX_W'(cand_idx);
    case (idx)
      2'd0, 2'd1: axis = AXIS_VERT;
      2'd2:       axis = AXIS_HORZ;
      default:    axis = AXIS_DIAG;
    endcase
  end

endmodule

// File: rtl/brick_field_ctrl.sv
// Brick-field manager: hit-point array, probe FSM for ball hits, combo score and level reload.
module brick_field_ctrl
  import brick_pkg::*;
#(
  parameter int GRID_COLS  = 16,
  parameter int BRICK_W    = 2,
  parameter int BRICK_ROWS = 7,
  parameter int ROW_OFFSET = 1,
  parameter int POS_W      = 4,
  parameter int HP_W       = 2,
  parameter int INIT_HP    = 1,
  parameter int COMBO_MAX  = 4,
  parameter int SCORE_W    = 10,
  localparam int N       = calc_n(BRICK_ROWS, GRID_COLS, BRICK_W),
  localparam int CNT_W   = $clog2(N + 1),
  localparam int COMBO_W = $clog2(COMBO_MAX + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hit_valid,
  output logic               hit_ready,
  input  logic [POS_W-1:0]   hit_row,
  input  logic [POS_W-1:0]   hit_col,
  input  logic [1:0]         hit_dir,
  input  logic               paddle_hit,
  input  logic               level_load,
  input  logic [HP_W-1:0]    level_hp,
  output logic               hit_ack,
  output logic               hit_bounce,
  output logic [1:0]         hit_axis,
  output logic [N-1:0]       brick_alive,
  output logic [CNT_W-1:0]   bricks_left,
  output logic [SCORE_W-1:0] score,
  output logic [COMBO_W-1:0] combo,
  output logic               level_clear,
  output logic               busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(N);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N - 1);
  localparam logic [COMBO_W-1:0] COMBO_ONE = COMBO_W'(1);
  localparam logic [COMBO_W-1:0] COMBO_TOP = COMBO_W'(COMBO_MAX);
  localparam logic [SCORE_W-1:0] SCORE_TOP = '1;

  brick_state_t state, next_state;

  logic [HP_W-1:0]  hp [N];
  logic [POS_W-1:0] lat_row, lat_col;
  logic [1:0]       lat_dir, probe_idx, found_axis, probe_axis;
  logic [IDX_W-1:0] load_idx, hit_brick, probe_index;
  logic             hit_found, probe_valid, probe_live;
  logic [SCORE_W:0] score_sum;

  brick_probe_addr #(
    .GRID_COLS (GRID_COLS),
    .BRICK_W   (BRICK_W),
    .BRICK_ROWS(BRICK_ROWS),
    .ROW_OFFSET(ROW_OFFSET),
    .POS_W     (POS_W),
    .IDX_W     (IDX_W)
  ) u_probe_addr (
    .row        (lat_row),
    .col        (lat_col),
    .dir        (lat_dir),
    .idx        (probe_idx),
    .valid      (probe_valid),
    .brick_index(probe_index),
    .axis       (probe_axis)
  );

  assign probe_live = probe_valid && (hp[probe_index] != '0);
  assign score_sum  = {1'b0, score} + (SCORE_W+1)'(combo);
  assign hit_ready  = (state == IDLE) && !level_load;
  assign busy       = (state != IDLE);

  for (genvar g = 0; g < N; g++) begin : g_alive
    assign brick_alive[g] = (hp[g] != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (level_load)     next_state = LOAD;
        else if (hit_valid) next_state = PROBE;
      end
      PROBE:   if (probe_live || (probe_idx == 2'd3)) next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      LOAD:    if (load_idx == LAST_IDX) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Paddle contact is applied last so it overrides any combo bump from the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) hp[i] <= HP_W'(INIT_HP);
      bricks_left <= (INIT_HP == 0) ? '0 : FULL_CNT;
      level_clear <= (INIT_HP == 0);
      score       <= '0;
      combo       <= COMBO_ONE;
      hit_ack     <= 1'b0;
      hit_bounce  <= 1'b0;
      hit_axis    <= AXIS_NONE;
      lat_row     <= '0;
      lat_col     <= '0;
      lat_dir     <= '0;
      probe_idx   <= '0;
      load_idx    <= '0;
      hit_found   <= 1'b0;
      hit_brick   <= '0;
      found_axis  <= AXIS_NONE;
    end else begin
      hit_ack     <= 1'b0;
      level_clear <= (bricks_left == '0);
      case (state)
        IDLE: begin
          if (level_load) begin
            load_idx <= '0;
          end else if (hit_valid) begin
            lat_row   <= hit_row;
            lat_col   <= hit_col;
            lat_dir   <= hit_dir;
            probe_idx <= '0;
          end
        end
        PROBE: begin
          if (probe_live) begin
            hit_found  <= 1'b1;
            hit_brick  <= probe_index;
            found_axis <= probe_axis;
          end else if (probe_idx == 2'd3) begin
            hit_found <= 1'b0;
          end else begin
            probe_idx <= probe_idx + 2'd1;
          end
        end
        COMMIT: begin
          if (hit_found) begin
            hp[hit_brick] <= hp[hit_brick] - HP_W'(1);
            if (hp[hit_brick] == HP_W'(1)) begin
              score       <= score_sum[SCORE_W] ? SCORE_TOP : score_sum[SCORE_W-1:0];
              combo       <= (combo >= COMBO_TOP) ? COMBO_TOP : combo + COMBO_ONE;
              bricks_left <= bricks_left - CNT_W'(1);
            end
          end
          hit_ack    <= 1'b1;
          hit_bounce <= hit_found;
          hit_axis   <= hit_found ? found_axis : AXIS_NONE;
        end
        LOAD: begin
          hp[load_idx] <= level_hp;
          load_idx     <= load_idx + IDX_W'(1);
          if (load_idx == LAST_IDX) begin
            bricks_left <= (level_hp != '0) ? FULL_CNT : '0;
            combo       <= COMBO_ONE;
          end
        end
        default: ;
      endcase
      if (paddle_hit) combo <= COMBO_ONE;
    end
  end

endmodule

// File: tb/tb_brick_field_ctrl.sv
// Directed, table-driven bench for brick_field_ctrl at default parameters (8x7 bricks).
module tb_brick_field_ctrl;

  localparam int N = 56;

  logic         clock = 1'b0;
  logic         reset;
  logic         hit_valid, hit_ready, paddle_hit, level_load;
  logic [3:0]   hit_row, hit_col;
  logic [1:0]   hit_dir, level_hp, hit_axis;
  logic         hit_ack, hit_bounce, level_clear, busy;
  logic [N-1:0] brick_alive;
  logic [5:0]   bricks_left;
  logic [9:0]   score;
  logic [2:0]   combo;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic [1:0] dir;
    int         lat;
    logic       bounce;
    logic [1:0] axis;
    int         score;
    int         combo;
    int         left;
    int         alive_idx;
    logic       alive_bit;
  } vec_t;

  vec_t vecs[7];

  brick_field_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_row    (hit_row),
    .hit_col    (hit_col),
    .hit_dir    (hit_dir),
    .paddle_hit (paddle_hit),
    .level_load (level_load),
    .level_hp   (level_hp),
    .hit_ack    (hit_ack),
    .hit_bounce (hit_bounce),
    .hit_axis   (hit_axis),
    .brick_alive(brick_alive),
    .bricks_left(bricks_left),
    .score      (score),
    .combo      (combo),
    .level_clear(level_clear),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one request; lat is the number of edges after acceptance until hit_ack is seen.
  task automatic applyStimulus(input logic [3:0] row, input logic [3:0] col, input logic [1:0] dir,
                               input int paddle_edge, input int load_edge, output int lat);
    @(negedge clock);
    hit_valid = 1'b1;
    hit_row   = row;
    hit_col   = col;
    hit_dir   = dir;
    @(posedge clock); #1;
    hit_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      paddle_hit = (k == paddle_edge);
      level_load = (k == load_edge);
      @(posedge clock); #1;
      paddle_hit = 1'b0;
      level_load = 1'b0;
      if (hit_ack) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runHit(input string name, input logic [3:0] row, input logic [3:0] col,
                        input logic [1:0] dir, input int paddle_edge, input int exp_lat,
                        input logic exp_bounce, input logic [1:0] exp_axis,
                        input int exp_score, input int exp_combo, input int exp_left);
    int lat;
    applyStimulus(row, col, dir, paddle_edge, 0, lat);
    checkOutput({name, " latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, " bounce"}, 64'(hit_bounce), 64'(exp_bounce));
    checkOutput({name, " axis"}, 64'(hit_axis), 64'(exp_axis));
    checkOutput({name, " score"}, 64'(score), 64'(exp_score));
    checkOutput({name, " combo"}, 64'(combo), 64'(exp_combo));
    checkOutput({name, " bricks_left"}, 64'(bricks_left), 64'(exp_left));
  endtask

  task automatic applyLoad(input logic [1:0] hp, input logic with_hit,
                           output int cnt, output logic bad_ready, output logic saw_ack);
    @(negedge clock);
    level_load = 1'b1;
    level_hp   = hp;
    hit_valid  = with_hit;
    hit_row    = 4'd1;
    hit_col    = 4'd0;
    hit_dir    = 2'b00;
    @(posedge clock); #1;
    level_load = 1'b0;
    hit_valid  = 1'b0;
    cnt = 0;
    bad_ready = 1'b0;
    saw_ack = 1'b0;
    while (busy && cnt < 100) begin
      cnt++;
      if (hit_ready) bad_ready = 1'b1;
      if (hit_ack) saw_ack = 1'b1;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    int          lat, cnt, m_score, m_combo, m_left;
    logic        bad_ready, saw_ack;
    logic [3:0]  r, c;

    vecs[0] = '{4'd1,  4'd4,  2'b00, 2, 1'b1, 2'b01, 1,  2, 55, 2,  1'b0};
    vecs[1] = '{4'd1,  4'd4,  2'b00, 4, 1'b1, 2'b10, 3,  3, 54, 1,  1'b0};
    vecs[2] = '{4'd12, 4'd8,  2'b11, 5, 1'b0, 2'b00, 3,  3, 54, 1,  1'b0};
    vecs[3] = '{4'd0,  4'd5,  2'b11, 5, 1'b1, 2'b11, 6,  4, 53, 3,  1'b0};
    vecs[4] = '{4'd0,  4'd4,  2'b11, 5, 1'b0, 2'b00, 6,  4, 53, 2,  1'b0};
    vecs[5] = '{4'd8,  4'd15, 2'b01, 3, 1'b1, 2'b01, 10, 4, 52, 55, 1'b0};
    vecs[6] = '{4'd0,  4'd0,  2'b00, 5, 1'b0, 2'b00, 10, 4, 52, 0,  1'b1};

    reset = 1'b0;
    hit_valid = 1'b0; paddle_hit = 1'b0; level_load = 1'b0;
    hit_row = '0; hit_col = '0; hit_dir = '0; level_hp = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    checkOutput("reset score", 64'(score), 64'(0));
    checkOutput("reset bricks_left", 64'(bricks_left), 64'(56));
    checkOutput("reset brick_alive", 64'(brick_alive), {8'h00, {56{1'b1}}});
    checkOutput("reset combo", 64'(combo), 64'(1));
    checkOutput("reset hit_ready", 64'(hit_ready), 64'(1));
    checkOutput("reset level_clear", 64'(level_clear), 64'(0));
    checkOutput("reset hit_ack", 64'(hit_ack), 64'(0));
    checkOutput("reset axis", 64'(hit_axis), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));

    for (int i = 0; i < 7; i++) begin
      runHit($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, vecs[i].dir, 0, vecs[i].lat,
             vecs[i].bounce, vecs[i].axis, vecs[i].score, vecs[i].combo, vecs[i].left);
      checkOutput($sformatf("vec%0d alive", i), 64'(brick_alive[vecs[i].alive_idx]), 64'(vecs[i].alive_bit));
      @(posedge clock); #1;
      checkOutput($sformatf("vec%0d ack single pulse", i), 64'(hit_ack), 64'(0));
      checkOutput($sformatf("vec%0d bounce held", i), 64'(hit_bounce), 64'(vecs[i].bounce));
    end

    // A load request while probing must be dropped.
    applyStimulus(4'd12, 4'd8, 2'b11, 0, 1, lat);
    checkOutput("busy load latency", 64'(lat), 64'(5));
    checkOutput("busy load bricks_left", 64'(bricks_left), 64'(52));
    checkOutput("busy load alive0", 64'(brick_alive[0]), 64'(1));
    @(posedge clock); #1;
    checkOutput("busy load idle after", 64'(busy), 64'(0));

    applyLoad(2'd2, 1'b1, cnt, bad_ready, saw_ack);
    checkOutput("load2 busy cycles", 64'(cnt), 64'(56));
    checkOutput("load2 ready low", 64'(bad_ready), 64'(0));
    checkOutput("load2 no ack", 64'(saw_ack), 64'(0));
    checkOutput("load2 combo", 64'(combo), 64'(1));
    checkOutput("load2 score kept", 64'(score), 64'(10));
    checkOutput("load2 bricks_left", 64'(bricks_left), 64'(56));
    checkOutput("load2 alive", 64'(brick_alive), {8'h00, {56{1'b1}}});

    runHit("dmg0", 4'd1, 4'd0, 2'b00, 0, 2, 1'b1, 2'b01, 10, 1, 56);
    checkOutput("dmg0 alive0", 64'(brick_alive[0]), 64'(1));
    runHit("kill0", 4'd1, 4'd0, 2'b00, 0, 2, 1'b1, 2'b01, 11, 2, 55);
    checkOutput("kill0 alive0", 64'(brick_alive[0]), 64'(0));

    applyLoad(2'd1, 1'b0, cnt, bad_ready, saw_ack);
    checkOutput("load1 busy cycles", 64'(cnt), 64'(56));
    checkOutput("load1 combo", 64'(combo), 64'(1));
    checkOutput("load1 score kept", 64'(score), 64'(11));
    checkOutput("load1 bricks_left", 64'(bricks_left), 64'(56));

    runHit("streak8",  4'd2, 4'd0, 2'b00, 0, 2, 1'b1, 2'b01, 12, 2, 55);
    runHit("streak9",  4'd2, 4'd2, 2'b00, 0, 2, 1'b1, 2'b01, 14, 3, 54);
    runHit("streak10", 4'd2, 4'd4, 2'b00, 0, 2, 1'b1, 2'b01, 17, 4, 53);
    runHit("streak11", 4'd2, 4'd6, 2'b00, 0, 2, 1'b1, 2'b01, 21, 4, 52);
    runHit("streak12", 4'd2, 4'd8, 2'b00, 0, 2, 1'b1, 2'b01, 25, 4, 51);
    runHit("paddle13", 4'd2, 4'd10, 2'b00, 2, 2, 1'b1, 2'b01, 29, 1, 50);

    // Clear the remaining bricks with a running score/combo model.
    m_score = 29; m_combo = 1; m_left = 50;
    for (int i = 0; i < N; i++) begin
      if (i >= 8 && i <= 13) continue;
      m_score += m_combo;
      m_combo = (m_combo < 4) ? m_combo + 1 : 4;
      m_left--;
      r = 4'(1 + i / 8);
      c = 4'((i % 8) * 2);
      runHit($sformatf("clear%0d", i), r, c, 2'b00, 0, 2, 1'b1, 2'b01, m_score, m_combo, m_left);
    end
    checkOutput("final score", 64'(score), 64'(223));
    checkOutput("final alive", 64'(brick_alive), 64'(0));
    checkOutput("clear not yet", 64'(level_clear), 64'(0));
    @(posedge clock); #1;
    checkOutput("clear one later", 64'(level_clear), 64'(1));

    @(negedge clock);
    level_load = 1'b1;
    level_hp   = 2'd3;
    @(posedge clock); #1;
    level_load = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("load abort busy", 64'(busy), 64'(0));
    checkOutput("load abort score", 64'(score), 64'(0));
    checkOutput("load abort bricks_left", 64'(bricks_left), 64'(56));
    checkOutput("load abort alive", 64'(brick_alive), {8'h00, {56{1'b1}}});
    checkOutput("load abort combo", 64'(combo), 64'(1));
    @(negedge clock);
    reset = 1'b1;

    @(negedge clock);
    hit_valid = 1'b1; hit_row = 4'd1; hit_col = 4'd6; hit_dir = 2'b11;
    @(posedge clock); #1;
    hit_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("probe abort busy", 64'(busy), 64'(0));
    checkOutput("probe abort ack", 64'(hit_ack), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    saw_ack = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
      if (hit_ack) saw_ack = 1'b1;
    end
    checkOutput("probe abort no late ack", 64'(saw_ack), 64'(0));
    checkOutput("probe abort alive3", 64'(brick_alive[3]), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
